// File: rtl/bcd_conv_seq.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock).
// Converts CHANNELS binary fields in sequence and presents all lanes together.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_bin holds CHANNELS fields of BIN_W bits
//   out_valid/ready output handshake; out_bcd holds CHANNELS lanes of DIGITS nibbles
//   out_ovf         per-channel flag, set when the field exceeds 10^DIGITS-1
//   busy            high while converting
module bcd_conv_seq #(
  parameter int unsigned BIN_W    = 8,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned CHANNELS = 6,
  parameter int unsigned SAT      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BIN_W-1:0]    in_bin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*4*DIGITS-1:0] out_bcd,
  output logic [CHANNELS-1:0]          out_ovf,
  output logic                         busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned CH_W  = $clog2(CHANNELS + 1);
  // Bits needed for 10^DIGITS (log2(10) rounded up to 3.322) plus one.
  localparam int unsigned DEC_W = (DIGITS * 3322 + 999) / 1000 + 1;
  localparam int unsigned CMP_W = (BIN_W > DEC_W) ? BIN_W : DEC_W;

  function automatic logic [CMP_W-1:0] max_dec();
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < int'(DIGITS); i++) p = p * CMP_W'(10);
    return p - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_DEC = max_dec();
  localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

  // Add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < int'(DIGITS); d++)
      if (b[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CHANNELS*BIN_W-1:0]   cap_q, cap_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d;
  logic [BIN_W-1:0]            bin_q, bin_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic                        in_ready_d, out_valid_d, busy_d;
  logic [CHANNELS*BCD_W-1:0]   out_bcd_d;
  logic [CHANNELS-1:0]         out_ovf_d;

  logic [BCD_W-1:0]            adj_c, iter_bcd_c, lane_c;
  logic [BIN_W-1:0]            iter_bin_c, next_field_c;
  logic [CH_W-1:0]             ch_nxt_c;
  logic                        ovf_cur_c;

  // One double-dabble step on the current scratch.
  always_comb begin
    adj_c      = add3(bcd_q);
    iter_bcd_c = (adj_c << 1) | BCD_W'(bin_q[BIN_W-1]);
    iter_bin_c = bin_q << 1;
  end

  // Lane selection: overflow flag of the current channel and the next field.
  always_comb begin
    ch_nxt_c     = ch_q + CH_W'(1);
    ovf_cur_c    = 1'b0;
    next_field_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (ch_q == CH_W'(k))     ovf_cur_c    = out_ovf[k];
      if (ch_nxt_c == CH_W'(k)) next_field_c = cap_q[k*BIN_W +: BIN_W];
    end
    lane_c = ((SAT != 0) && ovf_cur_c) ? NINES : iter_bcd_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    busy_d      = busy;
    out_bcd_d   = out_bcd;
    out_ovf_d   = out_ovf;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d    = CONV;
          cap_d      = in_bin;
          out_bcd_d  = '0;
          for (int k = 0; k < int'(CHANNELS); k++)
            out_ovf_d[k] = CMP_W'(in_bin[k*BIN_W +: BIN_W]) > MAX_DEC;
          bcd_d      = '0;
          bin_d      = in_bin[BIN_W-1:0];
          cnt_d      = '0;
          ch_d       = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CONV: begin
        bcd_d = iter_bcd_c;
        bin_d = iter_bin_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          for (int k = 0; k < int'(CHANNELS); k++)
            if (ch_q == CH_W'(k)) out_bcd_d[k*BCD_W +: BCD_W] = lane_c;
          cnt_d = '0;
          bcd_d = '0;
          bin_d = next_field_c;
          ch_d  = ch_nxt_c;
          if (ch_q == CH_W'(CHANNELS - 1)) begin
            state_d     = DONE;
            ch_d        = '0;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_bcd   <= '0;
      out_ovf   <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      out_bcd   <= out_bcd_d;
      out_ovf   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq: a saturating and a modulo instance
// driven from the same stimulus.
module tb_bcd_conv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_bin;

  logic        in_ready0, out_valid0, busy0;
  logic [47:0] out_bcd0;
  logic [5:0]  out_ovf0;
  logic        in_ready1, out_valid1, busy1;
  logic [47:0] out_bcd1;
  logic [5:0]  out_ovf1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd_conv_seq #(.BIN_W(8), .DIGITS(2), .CHANNELS(6), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_bin(in_bin), .out_valid(out_valid0), .out_ready(out_ready),
    .out_bcd(out_bcd0), .out_ovf(out_ovf0), .busy(busy0));

  bcd_conv_seq #(.BIN_W(8), .DIGITS(2), .CHANNELS(6), .SAT(0)) dut_mod (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_bin(in_bin), .out_valid(out_valid1), .out_ready(out_ready),
    .out_bcd(out_bcd1), .out_ovf(out_ovf1), .busy(busy1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [47:0] pk(input logic [7:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Wait for in_ready, then present one transaction for a single accept edge.
  task automatic start(input logic [47:0] v);
    int n;
    n = 0;
    while (!in_ready0 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("in_ready_timeout", 64'(in_ready0), 64'd1);
    @(negedge clk);
    in_bin   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid0 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  int          lat;
  logic [7:0]  basic_v [7] = '{8'd1, 8'd2, 8'd4, 8'd25, 8'd40, 8'd50, 8'd59};
  logic [7:0]  basic_e [7] = '{8'h01, 8'h02, 8'h04, 8'h25, 8'h40, 8'h50, 8'h59};
  logic [47:0] held;
  logic        bad;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_bin    = '0;

    // Reset and idle state.
    repeat (3) @(posedge clk);
    #1 chk("rst_in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready0), 64'd1);
    chk("idle_out_valid", 64'(out_valid0), 64'd0);
    chk("idle_busy", 64'(busy0), 64'd0);
    chk("idle_out_bcd", 64'(out_bcd0), 64'd0);
    chk("idle_out_ovf", 64'(out_ovf0), 64'd0);

    // Uniform values across all lanes; latency measured each time.
    for (int i = 0; i < 7; i++) begin
      start({6{basic_v[i]}});
      chk("conv_busy", 64'(busy0), 64'd1);
      wait_done(lat);
      chk("basic_latency", 64'(lat), 64'd48);
      chk("basic_bcd", 64'(out_bcd0), 64'({6{basic_e[i]}}));
      chk("basic_ovf", 64'(out_ovf0), 64'd0);
    end

    // Mixed channels.
    start(pk(8'd0, 8'd9, 8'd10, 8'd23, 8'd31, 8'd99));
    wait_done(lat);
    chk("mixed_bcd_sat", 64'(out_bcd0), 64'(pk(8'h00, 8'h09, 8'h10, 8'h23, 8'h31, 8'h99)));
    chk("mixed_bcd_mod", 64'(out_bcd1), 64'(pk(8'h00, 8'h09, 8'h10, 8'h23, 8'h31, 8'h99)));
    chk("mixed_ovf", 64'(out_ovf0), 64'd0);

    // Overflow on channel 2: saturate vs modulo.
    start(pk(8'd7, 8'd7, 8'd200, 8'd7, 8'd7, 8'd7));
    wait_done(lat);
    chk("ovf200_bcd_sat", 64'(out_bcd0), 64'(pk(8'h07, 8'h07, 8'h99, 8'h07, 8'h07, 8'h07)));
    chk("ovf200_ovf_sat", 64'(out_ovf0), 64'b000100);
    chk("ovf200_bcd_mod", 64'(out_bcd1), 64'(pk(8'h07, 8'h07, 8'h00, 8'h07, 8'h07, 8'h07)));
    chk("ovf200_ovf_mod", 64'(out_ovf1), 64'b000100);

    start(pk(8'd7, 8'd7, 8'd255, 8'd7, 8'd7, 8'd7));
    wait_done(lat);
    chk("ovf255_bcd_mod", 64'(out_bcd1), 64'(pk(8'h07, 8'h07, 8'h55, 8'h07, 8'h07, 8'h07)));
    chk("ovf255_bcd_sat", 64'(out_bcd0), 64'(pk(8'h07, 8'h07, 8'h99, 8'h07, 8'h07, 8'h07)));

    // Boundary: 99 fits, 100 overflows.
    start(pk(8'd99, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_done(lat);
    chk("edge_ovf", 64'(out_ovf0), 64'b000010);
    chk("edge_bcd_mod", 64'(out_bcd1), 64'(pk(8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00)));

    // Backpressure with input noise during CONV and DONE.
    start(pk(8'd12, 8'd34, 8'd56, 8'd78, 8'd90, 8'd11));
    out_ready = 1'b0;
    bad = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 200) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_bin   = {$urandom, $urandom};
      @(posedge clk); #1;
      lat++;
      if (in_ready0) bad = 1'b1;
    end
    chk("bp_latency", 64'(lat), 64'd48);
    held = out_bcd0;
    chk("bp_bcd", 64'(held), 64'(pk(8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'h11)));
    repeat (20) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_bin   = {$urandom, $urandom};
      @(posedge clk); #1;
      if (in_ready0 || !out_valid0 || out_bcd0 !== held || out_ovf0 !== 6'd0) bad = 1'b1;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_accept_valid", 64'(out_valid0), 64'd0);
    chk("bp_accept_ready", 64'(in_ready0), 64'd1);
    chk("bp_retain_bcd", 64'(out_bcd0), 64'(held));

    // Asynchronous reset 20 cycles into a conversion.
    start({6{8'd200}});
    repeat (19) @(posedge clk);
    #1 chk("mid_busy", 64'(busy0), 64'd1);
    chk("mid_ovf_before", 64'(out_ovf0), 64'h3f);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_ready", 64'(in_ready0), 64'd1);
    chk("mid_rst_ovf", 64'(out_ovf0), 64'd0);
    chk("mid_rst_bcd", 64'(out_bcd0), 64'd0);
    bad = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (out_valid0) bad = 1'b1; end
    @(negedge clk) rst_n = 1'b1;
    repeat (60) begin @(posedge clk); #1; if (out_valid0 || out_valid1) bad = 1'b1; end
    chk("mid_no_valid", 64'(bad), 64'd0);

    start({6{8'd37}});
    wait_done(lat);
    chk("post_rst_latency", 64'(lat), 64'd48);
    chk("post_rst_bcd", 64'(out_bcd0), 64'({6{8'h37}}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
- Parametrised, iterative binary-to-BCD converter for the RTC display and readout path.
- Converts CHANNELS packed binary fields (sec, min, hour, days, months, years by default) to packed BCD using shift-and-add-3 (double dabble), one bit per clock, channels in sequence.
- Adds a valid/ready handshake on both sides, a configurable digit count, and per-channel overflow detection with optional saturation.

Parameters:
- BIN_W, 8, width of each binary input field (>=1).
- DIGITS, 2, BCD digits per channel; output width per channel is 4*DIGITS.
- CHANNELS, 6, number of independent fields converted per transaction (>=1).
- SAT, 1, overflow mode: 1 saturates the result to all nines; 0 keeps the value modulo 10^DIGITS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  converter idle and able to accept.
- in_bin  in  CHANNELS*BIN_W  packed binary fields; channel k occupies bits [k*BIN_W +: BIN_W].
- out_valid  out  1  out_bcd and out_ovf hold a complete result.
- out_ready  in  1  downstream accepts the result.
- out_bcd  out  CHANNELS*4*DIGITS  packed BCD; channel k occupies bits [k*4*DIGITS +: 4*DIGITS]; digit 0 (units) is the low nibble.
- out_ovf  out  CHANNELS  per-channel flag; bit k is set when in_bin[k] > 10^DIGITS-1.
- busy  out  1  high while in state CONV.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, out_bcd=0, out_ovf=0.
  - All internal registers (shift scratch, bit counter, channel index, captured inputs) clear.
  - Reset asserted mid-conversion discards the transaction; no partial result is ever presented.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at edge E0: capture all of in_bin, compute all out_ovf bits from the captured values, clear out_bcd, set channel index=0 and bit counter=0, go to CONV.
- CONV:
  - in_ready=0, busy=1; in_valid and in_bin are ignored.
  - Each cycle performs one double-dabble iteration on the current channel: every BCD nibble >=5 gets +3, then the {bcd, bin} scratch shifts left by 1.
  - The iteration is computed combinationally within the cycle and registered at the edge.
  - After BIN_W iterations, the channel's DIGITS-digit result is written into its out_bcd lane on that same edge. When that channel's ovf=1 and SAT=1, all nines (0x9 per digit) are written instead.
  - The channel index then increments and the scratch reloads from the next captured field.
  - Channel k completes at edge E0+(k+1)*BIN_W.
  - After the last channel, go to DONE. out_valid rises at edge E0+CHANNELS*BIN_W, which is 48 cycles with the defaults.
- Modulo semantics: with SAT=0 and overflow, the written value is (value mod 10^DIGITS), which is what a DIGITS-wide double dabble naturally produces.
- DONE:
  - out_valid=1; out_bcd and out_ovf are held stable until accepted.
  - On out_valid&&out_ready, go to IDLE; out_valid falls and in_ready rises at that edge. There is no same-cycle input/output overlap.
  - out_bcd and out_ovf retain their values in IDLE until the next accept.
- Output handshake: out_ready low while out_valid is high stalls indefinitely with no data change.
- Width rules:
  - BIN_W=1 is legal.
  - DIGITS large enough that 10^DIGITS > 2^BIN_W-1 makes out_ovf constant 0.
  - The overflow comparison is done at max(BIN_W, ceil(DIGITS*log2(10))+1) bits, so there is no truncation.
- Counters:
  - Bit counter width is clog2(BIN_W+1); channel index width is clog2(CHANNELS+1).
  - Both wrap only via explicit reload, never via arithmetic overflow.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_bcd=0, out_ovf=0.
- Basic conversion (defaults): all six channels = 1, then 2, 4, 25, 40, 50, 59, each a separate transaction with out_ready=1.
  - Each lane must read 0x01, 0x02, 0x04, 0x25, 0x40, 0x50, 0x59 respectively, with out_ovf=0.
  - out_valid must rise exactly 48 cycles after the accept edge.
- Mixed channels: in_bin channels 0..5 = {0, 9, 10, 23, 31, 99} -> lanes 0x00, 0x09, 0x10, 0x23, 0x31, 0x99, with out_ovf=0.
- Overflow: channel 2 = 200, others = 7.
  - SAT=1 -> lane 2 = 0x99 and out_ovf=6'b000100.
  - SAT=0 -> lane 2 = 0x00 with the same out_ovf.
  - Channel 2 = 255 with SAT=0 -> lane 2 = 0x55.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, and toggle in_valid/in_bin during CONV and DONE.
  - Result must not change and in_ready must stay 0.
  - Accept occurs on the first out_ready=1 edge.
  - in_ready=1 on the following cycle.
- Reset mid-operation: drop rst_n asynchronously at 20 cycles into CONV -> outputs clear immediately, with no out_valid pulse.
  - The next transaction (all channels 37) yields 0x37 in every lane.
